checkerboard_state_scanner: RTL

Read-side client of `checkerboard_state_ram`. On a `start` pulse it sweeps all 64 board cells (8×8, address = row*8+col) through the RAM read port. It streams each (address, state) pair out over a valid/ready interface to downstream consumers such as a display or UART formatter. While streaming it tallies black, white and empty stones, and it flags any illegal cell encoding.

---
 rtl/checkerboard_state_scanner.sv | 128 ++++++++++++
 1 files changed

// File: rtl/checkerboard_state_scanner.sv
// Sweeps every board cell through the RAM read port and streams (addr, state) out on valid/ready,
// tallying black/white/empty stones and flagging the illegal 2'b11 encoding.
module checkerboard_state_scanner #(
  parameter int ADDR_W = 6,
  parameter int CELLS  = 64,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output logic [1:0]        out_state,
  output logic [CNT_W-1:0]  black_count,
  output logic [CNT_W-1:0]  white_count,
  output logic [CNT_W-1:0]  empty_count,
  output logic              invalid_flag
);

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(CELLS);

  state_t              state_q, state_d;
  logic [ADDR_W:0]     idx_q, idx_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q, out_addr_d;
  logic [1:0]          out_state_q, out_state_d;
  logic [CNT_W-1:0]    black_q, black_d, white_q, white_d, empty_q, empty_d;
  logic                inv_q, inv_d;
  logic                capture, xfer;
  logic [ADDR_W:0]     idx_inc;

  assign idx_inc = idx_q + 1'b1;
  // A new cell may enter the output register when it is empty or being drained this edge.
  assign capture = (state_q == SCAN) && (idx_q < LAST_IDX) && (!out_valid_q || out_ready);
  assign xfer    = out_valid_q && out_ready;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    rd_addr_d   = rd_addr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_state_d = out_state_q;
    black_d     = black_q;
    white_d     = white_q;
    empty_d     = empty_q;
    inv_d       = inv_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = SCAN;
          idx_d     = '0;
          rd_addr_d = '0;
          black_d   = '0;
          white_d   = '0;
          empty_d   = '0;
          inv_d     = 1'b0;
        end
      end
      SCAN: begin
        if (capture) begin
          out_valid_d = 1'b1;
          out_addr_d  = idx_q[ADDR_W-1:0];
          out_state_d = rd_data;
          idx_d       = idx_inc;
          rd_addr_d   = idx_inc[ADDR_W-1:0];
          case (rd_data)
            2'b00:   empty_d = empty_q + CNT_W'(1);
            2'b01:   black_d = black_q + CNT_W'(1);
            2'b10:   white_d = white_q + CNT_W'(1);
            default: inv_d   = 1'b1;
          endcase
        end else if (xfer) begin
          out_valid_d = 1'b0;
          if (idx_q == LAST_IDX) state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_state_q <= '0;
      black_q     <= '0;
      white_q     <= '0;
      empty_q     <= '0;
      inv_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      rd_addr_q   <= rd_addr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_state_q <= out_state_d;
      black_q     <= black_d;
      white_q     <= white_d;
      empty_q     <= empty_d;
      inv_q       <= inv_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign rd_addr      = rd_addr_q;
  assign out_valid    = out_valid_q;
  assign out_addr     = out_addr_q;
  assign out_state    = out_state_q;
  assign black_count  = black_q;
  assign white_count  = white_q;
  assign empty_count  = empty_q;
  assign invalid_flag = inv_q;

endmodule
